baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Parametrised fractional baud-rate generator that supersedes the fixed-divisor `baud_generator`. It produces three outputs from one system clock:
- an oversampling tick for the UART receiver;
- a bit-rate tick for the transmitter;
- a 50 % duty `clk_out`.

The divisor is runtime-programmable with a fractional part, updates are glitch-free, and a phase-resync input lets the receiver align to a start-bit edge.

## Interface
- `INT_W`, 16: width of the integer divisor (clock cycles per oversample tick).
- `FRAC_W`, 8: width of the fractional divisor (units of 2^-FRAC_W cycle).
- `OVERSAMPLE`, 16: oversample ticks per bit; even, ≥ 4.
- `DIV_INT_RST`, 54: integer divisor loaded at reset.
- `DIV_FRAC_RST`, 0: fractional divisor loaded at reset.

Ports:
- `clk_in`, in, 1: system clock; all logic is on the rising edge.
- `nrst_in`, in, 1: asynchronous, active-low reset.
- `en_in`, in, 1: generator enable; low holds the phase at the sync state.
- `sync_in`, in, 1: single-cycle phase restart.
- `cfg_load_in`, in, 1: single-cycle strobe that captures the divisor inputs.
- `div_int_in`, in, `INT_W`: new integer divisor.
- `div_frac_in`, in, `FRAC_W`: new fractional divisor.
- `cfg_pending_out`, out, 1: captured divisor not yet applied.
- `os_tick_out`, out, 1: one-cycle pulse per oversample period.
- `mid_tick_out`, out, 1: one-cycle pulse at the bit centre.
- `baud_tick_out`, out, 1: one-cycle pulse per bit.
- `clk_out`, out, 1: bit-rate square wave.

## Operation
- **Divisor.** Effective period per oversample tick is `div_int + div_frac/2^FRAC_W` cycles.
  - `div_int` values below 2 are clamped to 2.
- **Integer counter.** The down-counter `cnt` is loaded with `period-1`. `os_tick` fires when `cnt == 0` and `en_in` is high.
- **Fractional accumulator.** On each `os_tick`, `acc` takes the low `FRAC_W` bits of `acc + div_frac`.
  - `carry` is the overflow bit of that add.
  - The next period is `div_int + carry`.
  - The first period after reset, sync or enable uses `acc = 0` and is exactly `div_int`.
- **Oversample counter.** `os_cnt` runs 0..`OVERSAMPLE-1` and advances on each `os_tick`.
  - `baud_tick` fires on the `os_tick` where `os_cnt` wraps from `OVERSAMPLE-1` to 0.
  - `mid_tick` fires on the `os_tick` where `os_cnt` goes from `OVERSAMPLE/2-1` to `OVERSAMPLE/2`.
  - `clk_out` is high while `os_cnt < OVERSAMPLE/2`.
- **Config load.** `cfg_load_in` copies the divisor inputs into a shadow register and sets `cfg_pending_out`.
  - The shadow is applied at the next `os_tick`, or immediately if `en_in` is low.
  - Applying the shadow clears `cfg_pending_out` and clears `acc`.
  - A second load before the shadow is applied overwrites the shadow; the last load wins.
- **Sync.** `sync_in` clears `cnt`, `acc` and `os_cnt`, and drops `clk_out` to 0.
  - A pending config is applied in the same cycle as the sync.
  - `sync_in` has priority over a simultaneous `os_tick`; that tick is suppressed.
- **Enable.** While `en_in` is low, the block holds the sync state and all tick outputs are 0.
- **Reset values.**
  - Outputs: all ticks 0, `clk_out` 0, `cfg_pending_out` 0.
  - Divisor: `DIV_INT_RST`/`DIV_FRAC_RST`.
  - Counters: `cnt`, `acc` and `os_cnt` are 0.
  - Reset asserted mid-operation returns the block to this state immediately (asynchronously).

## Timing
- All outputs are registered; every tick is exactly one `clk_in` cycle wide.
- Ticks are mutually coincident only as defined: `baud_tick` and `mid_tick` always coincide with an `os_tick`.
- **First `os_tick`.** It is asserted `div_int` cycles after one of:
  - the first rising edge with `nrst_in` and `en_in` high;
  - the edge sampling `sync_in` high.
- **Tick spacing.** Successive `os_tick`s are `div_int` or `div_int+1` cycles apart. Over `2^FRAC_W` ticks the average error is 0.
- **First bit ticks.** `mid_tick` is the `OVERSAMPLE/2`-th `os_tick` after sync. `baud_tick` is the `OVERSAMPLE`-th.
- **Config latency.** A config captured at edge N takes effect for the period starting after the next `os_tick`. The old period always completes; there is no runt tick.

## Structure
- Package `baud_pkg`: default widths, the reset divisor constants, and a `div_cfg` struct (int, frac).
- Sub-module `frac_divider`: holds `cnt`, `acc`, the carry logic and the shadow-config logic, and outputs `os_tick`.
- The top level adds `os_cnt`, `mid_tick`/`baud_tick` decode and `clk_out`.

## Test plan
- **Reset defaults.** Reset, then `en_in` = 1 with default parameters:
  - `os_tick` every 54 cycles, `baud_tick` every 864 cycles;
  - `clk_out` high 432 cycles and low 432 cycles;
  - all outputs 0 while `nrst_in` = 0.
- **Fractional divisor.** Load `div_int` = 3, `div_frac` = 128 (`FRAC_W` = 8), then sync.
  - `os_tick` spacings are 3, 3, 4, 3, 4, 3, 4, …
  - 16 bits take exactly 896 − 0.5 rounding, i.e. 3.5 × 256 cycles ± 1.
- **Config mid-period.** Load `div_int` = 10 at cycle 20 of a 54-cycle period.
  - `cfg_pending_out` is high until the tick at cycle 54.
  - The next spacing is 10.
  - A second load of 12 before cycle 54 results in a spacing of 12.
- **Sync behaviour.** Pulse `sync_in` mid-bit:
  - `clk_out` goes to 0;
  - `os_cnt` restarts and the colliding tick is suppressed;
  - `mid_tick` fires 8 × 54 cycles later.
- **Divisor clamp.** `div_int` = 0 or 1 → ticks every 2 cycles. Toggle `en_in` low → outputs are 0 and the phase restarts on re-enable.
- **Async reset mid-operation.** Assert `nrst_in` between clock edges mid-bit:
  - outputs clear without waiting for a clock edge;
  - the divisor reverts to 54.

Source files
------------

// File: rtl/baud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : baud_pkg
// Purpose  : Shared defaults for the fractional baud-rate generator: default
//            divisor widths, reset divisor, minimum legal integer divisor and
//            the divisor configuration record.
// Revision : 1.0 - initial release
// ============================================================================
package baud_pkg;

    localparam int DEF_INT_W        = 16;
    localparam int DEF_FRAC_W       = 8;
    localparam int DEF_OVERSAMPLE   = 16;
    localparam int DEF_DIV_INT_RST  = 54;
    localparam int DEF_DIV_FRAC_RST = 0;

    // Smallest integer divisor that still leaves a low cycle between ticks.
    localparam int MIN_DIV_INT      = 2;

    // Divisor record at the default widths.
    typedef struct packed {
        logic [DEF_INT_W-1:0]  div_int;
        logic [DEF_FRAC_W-1:0] div_frac;
    } div_cfg_t;

    localparam div_cfg_t DIV_CFG_RST = '{
        div_int:  DEF_INT_W'(DEF_DIV_INT_RST),
        div_frac: DEF_FRAC_W'(DEF_DIV_FRAC_RST)
    };

endpackage : baud_pkg
`default_nettype wire

// File: rtl/frac_divider.sv
`default_nettype none
// ============================================================================
// Module   : frac_divider
// Purpose  : Fractional clock divider producing the oversample tick. Holds the
//            period down-counter, the fractional accumulator and the shadow
//            divisor register that is applied only at period boundaries.
// Ports    : clk_in/nrst_in      clock, async active-low reset
//            en_in/sync_in       enable, phase restart
//            cfg_load_in         capture div_int_in/div_frac_in into shadow
//            cfg_pending_out     shadow captured but not yet applied
//            os_tick_out         registered oversample tick
//            tick_now_out        the tick that os_tick_out shows next cycle
//            restart_out         phase is being forced to the sync state
// Revision : 1.0 - initial release
// ============================================================================
module frac_divider
    import baud_pkg::*;
#(
    parameter int INT_W        = DEF_INT_W,
    parameter int FRAC_W       = DEF_FRAC_W,
    parameter int DIV_INT_RST  = DEF_DIV_INT_RST,
    parameter int DIV_FRAC_RST = DEF_DIV_FRAC_RST
) (
    input  logic              clk_in,
    input  logic              nrst_in,
    input  logic              en_in,
    input  logic              sync_in,
    input  logic              cfg_load_in,
    input  logic [INT_W-1:0]  div_int_in,
    input  logic [FRAC_W-1:0] div_frac_in,
    output logic              cfg_pending_out,
    output logic              os_tick_out,
    output logic              tick_now_out,
    output logic              restart_out
);

    typedef struct packed {
        logic [INT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } cfg_t;

    localparam cfg_t CFG_RST = '{
        div_int:  INT_W'(DIV_INT_RST),
        div_frac: FRAC_W'(DIV_FRAC_RST)
    };

    cfg_t              cur_cfg;
    cfg_t              shadow_cfg;
    cfg_t              in_cfg;
    cfg_t              apply_cfg;
    cfg_t              new_cfg;
    logic              pending;
    logic              running;
    logic [INT_W-1:0]  cnt;
    logic [INT_W-1:0]  eff_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic              restart;
    logic              tick_now;
    logic              apply;

    always_comb begin
        in_cfg   = '{div_int: div_int_in, div_frac: div_frac_in};
        restart  = sync_in | ~en_in;
        // running is low on the first enabled edge, which only loads cnt.
        tick_now = en_in & running & ~sync_in & (cnt == '0);
        // While restarting there is no period in flight, so a config is
        // applied at once; a load in that same cycle bypasses the shadow.
        apply     = restart ? (pending | cfg_load_in) : (tick_now & pending);
        apply_cfg = (restart & cfg_load_in) ? in_cfg : shadow_cfg;
        new_cfg   = apply ? apply_cfg : cur_cfg;
        eff_int   = (new_cfg.div_int < INT_W'(MIN_DIV_INT)) ?
                    INT_W'(MIN_DIV_INT) : new_cfg.div_int;
        sum       = {1'b0, acc} + {1'b0, cur_cfg.div_frac};
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            cur_cfg     <= CFG_RST;
            shadow_cfg  <= CFG_RST;
            pending     <= 1'b0;
            running     <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            os_tick_out <= 1'b0;
        end else begin
            cur_cfg     <= new_cfg;
            os_tick_out <= tick_now;

            if (cfg_load_in) begin
                shadow_cfg <= in_cfg;
            end
            // A load coinciding with a tick keeps the new value pending for
            // the following boundary while the older shadow is applied now.
            if (cfg_load_in && !restart) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end

            if (!en_in) begin
                running <= 1'b0;
                cnt     <= '0;
                acc     <= '0;
            end else if (sync_in || !running) begin
                running <= 1'b1;
                cnt     <= eff_int - INT_W'(1);
                acc     <= '0;
            end else if (tick_now) begin
                if (apply) begin
                    // Fresh divisor starts with a clean accumulator.
                    acc <= '0;
                    cnt <= eff_int - INT_W'(1);
                end else begin
                    acc <= sum[FRAC_W-1:0];
                    cnt <= eff_int - INT_W'(1) + INT_W'(sum[FRAC_W]);
                end
            end else begin
                cnt <= cnt - INT_W'(1);
            end
        end
    end

    assign cfg_pending_out = pending;
    assign tick_now_out    = tick_now;
    assign restart_out     = restart;

endmodule : frac_divider
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Purpose  : Fractional baud-rate generator. Produces an oversample tick, a
//            bit-centre tick, a bit-rate tick and a 50 % bit-rate clock.
// Ports    : clk_in/nrst_in      clock, async active-low reset
//            en_in               enable (low holds the sync state)
//            sync_in             single-cycle phase restart
//            cfg_load_in         capture div_int_in/div_frac_in
//            cfg_pending_out     captured divisor not yet applied
//            os_tick_out         oversample tick
//            mid_tick_out        bit-centre tick
//            baud_tick_out       bit tick
//            clk_out             bit-rate square wave
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int INT_W        = DEF_INT_W,
    parameter int FRAC_W       = DEF_FRAC_W,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int DIV_INT_RST  = DEF_DIV_INT_RST,
    parameter int DIV_FRAC_RST = DEF_DIV_FRAC_RST
) (
    input  logic              clk_in,
    input  logic              nrst_in,
    input  logic              en_in,
    input  logic              sync_in,
    input  logic              cfg_load_in,
    input  logic [INT_W-1:0]  div_int_in,
    input  logic [FRAC_W-1:0] div_frac_in,
    output logic              cfg_pending_out,
    output logic              os_tick_out,
    output logic              mid_tick_out,
    output logic              baud_tick_out,
    output logic              clk_out
);

    localparam int              OS_W       = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF    = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_MID_PRE = OS_W'(OVERSAMPLE / 2 - 1);

    logic            tick_now;
    logic            restart;
    logic [OS_W-1:0] os_cnt;
    logic [OS_W-1:0] os_cnt_nxt;

    frac_divider #(
        .INT_W        (INT_W),
        .FRAC_W       (FRAC_W),
        .DIV_INT_RST  (DIV_INT_RST),
        .DIV_FRAC_RST (DIV_FRAC_RST)
    ) u_frac_divider (
        .clk_in          (clk_in),
        .nrst_in         (nrst_in),
        .en_in           (en_in),
        .sync_in         (sync_in),
        .cfg_load_in     (cfg_load_in),
        .div_int_in      (div_int_in),
        .div_frac_in     (div_frac_in),
        .cfg_pending_out (cfg_pending_out),
        .os_tick_out     (os_tick_out),
        .tick_now_out    (tick_now),
        .restart_out     (restart)
    );

    always_comb begin
        os_cnt_nxt = os_cnt;
        if (restart) begin
            os_cnt_nxt = '0;
        end else if (tick_now) begin
            os_cnt_nxt = (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end
    end

    // Bit ticks are decoded from the same strobe that sets os_tick_out, so
    // they always land in the same cycle as their oversample tick.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            os_cnt        <= '0;
            mid_tick_out  <= 1'b0;
            baud_tick_out <= 1'b0;
            clk_out       <= 1'b0;
        end else begin
            os_cnt        <= os_cnt_nxt;
            mid_tick_out  <= tick_now & (os_cnt == OS_MID_PRE);
            baud_tick_out <= tick_now & (os_cnt == OS_LAST);
            // The sync/disable cycle forces the clock low even though the
            // phase counter reads zero.
            clk_out       <= ~restart & (os_cnt_nxt < OS_HALF);
        end
    end

endmodule : baud_tick_gen
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_gen
// Purpose  : Directed self-checking bench for baud_tick_gen (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_baud_tick_gen;

    logic        clk_in = 1'b0;
    logic        nrst_in;
    logic        en_in;
    logic        sync_in;
    logic        cfg_load_in;
    logic [15:0] div_int_in;
    logic [7:0]  div_frac_in;
    logic        cfg_pending_out;
    logic        os_tick_out;
    logic        mid_tick_out;
    logic        baud_tick_out;
    logic        clk_out;

    wire  [4:0]  outs = {os_tick_out, mid_tick_out, baud_tick_out, clk_out, cfg_pending_out};

    int cyc    = 0;
    int checks = 0;
    int passed = 0;
    int fails  = 0;

    baud_tick_gen dut (
        .clk_in          (clk_in),
        .nrst_in         (nrst_in),
        .en_in           (en_in),
        .sync_in         (sync_in),
        .cfg_load_in     (cfg_load_in),
        .div_int_in      (div_int_in),
        .div_frac_in     (div_frac_in),
        .cfg_pending_out (cfg_pending_out),
        .os_tick_out     (os_tick_out),
        .mid_tick_out    (mid_tick_out),
        .baud_tick_out   (baud_tick_out),
        .clk_out         (clk_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       sig = os_tick_out;
            1:       sig = mid_tick_out;
            2:       sig = baud_tick_out;
            3:       sig = (clk_out == 1'b0);
            default: sig = (clk_out == 1'b1);
        endcase
    endfunction

    // Waits (bounded) at negedges for the selected event; at = -1 on timeout.
    task automatic wait_sig(input int which, input int bound, output int at);
        bit found;
        found = 1'b0;
        at    = -1;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk_in);
            if (sig(which)) begin
                at    = cyc;
                found = 1'b1;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic load(input int di, input int df);
        div_int_in  = 16'(di);
        div_frac_in = 8'(df);
        cfg_load_in = 1'b1;
        @(negedge clk_in);
        cfg_load_in = 1'b0;
    endtask

    task automatic sync_pulse(input bit with_load, input int di, input int df);
        div_int_in  = 16'(di);
        div_frac_in = 8'(df);
        cfg_load_in = with_load;
        sync_in     = 1'b1;
        @(negedge clk_in);
        cfg_load_in = 1'b0;
        sync_in     = 1'b0;
    endtask

    initial begin
        int c0, cs, t0, at, prev;
        int exp_os [5] = '{3, 6, 10, 13, 17};
        logic [4:0] seen;

        nrst_in = 1'b0; en_in = 1'b1; sync_in = 1'b0; cfg_load_in = 1'b0;
        div_int_in = '0; div_frac_in = '0;

        // Reset defaults
        step(3);
        check("rst_outputs", 32'(outs), 0);
        nrst_in = 1'b1;
        @(negedge clk_in); c0 = cyc;
        check("en_clk_high", 32'(clk_out), 1);
        wait_sig(0, 200, at);  check("dflt_os1", at - c0, 54);
        wait_sig(0, 200, at);  check("dflt_os2", at - c0, 108);
        wait_sig(3, 1000, at); check("dflt_clk_fall", at - c0, 432);
        check("dflt_mid_at_fall", 32'(mid_tick_out), 1);
        wait_sig(4, 1000, at); check("dflt_clk_rise", at - c0, 864);
        check("dflt_baud_at_rise", 32'({baud_tick_out, os_tick_out}), 3);

        // Fractional divisor 3 + 128/256
        load(3, 128);
        check("frac_pending", 32'(cfg_pending_out), 1);
        sync_pulse(1'b0, 0, 0); cs = cyc;
        check("frac_applied_on_sync", 32'(cfg_pending_out), 0);
        for (int k = 0; k < 5; k++) begin
            wait_sig(0, 20, at);
            check($sformatf("frac_os%0d", k + 1), at - cs, exp_os[k]);
        end
        wait_sig(1, 100, at); check("frac_mid1", at - cs, 27);
        for (int b = 0; b < 16; b++) begin
            wait_sig(2, 200, at);
            if (b == 0) check("frac_baud1", at - cs, 55);
        end
        check("frac_baud16", at - cs, 895);

        // Config load mid-period
        sync_pulse(1'b1, 54, 0);
        wait_sig(0, 100, at); t0 = at;
        step(19); load(10, 0);
        check("mid_load_pending", 32'(cfg_pending_out), 1);
        wait_sig(0, 100, at); check("mid_load_old_period", at - t0, 54);
        check("mid_load_cleared", 32'(cfg_pending_out), 0);
        prev = at;
        wait_sig(0, 100, at); check("mid_load_new_period", at - prev, 10);

        sync_pulse(1'b1, 54, 0);
        wait_sig(0, 100, at); t0 = at;
        step(19); load(10, 0);
        step(9);  load(12, 0);
        check("reload_pending", 32'(cfg_pending_out), 1);
        wait_sig(0, 100, at); check("reload_old_period", at - t0, 54);
        prev = at;
        wait_sig(0, 100, at); check("reload_last_wins", at - prev, 12);

        // Sync colliding with a tick mid-bit
        sync_pulse(1'b1, 54, 0);
        wait_sig(2, 1000, at);
        for (int k = 0; k < 3; k++) wait_sig(0, 100, at);
        t0 = at;
        check("sync_pre_clk_high", 32'(clk_out), 1);
        step(53);
        sync_pulse(1'b0, 0, 0); cs = cyc;
        check("sync_tick_suppressed", 32'(os_tick_out), 0);
        check("sync_clk_low", 32'(clk_out), 0);
        wait_sig(0, 100, at);  check("sync_os1", at - cs, 54);
        wait_sig(1, 1000, at); check("sync_mid", at - cs, 432);

        // Divisor clamp
        sync_pulse(1'b1, 0, 0); cs = cyc;
        wait_sig(0, 10, at); check("clamp0_first", at - cs, 2);
        prev = at;
        wait_sig(0, 10, at); check("clamp0_space", at - prev, 2);
        sync_pulse(1'b1, 1, 0); cs = cyc;
        wait_sig(0, 10, at); check("clamp1_first", at - cs, 2);
        prev = at;
        wait_sig(0, 10, at); check("clamp1_space", at - prev, 2);

        // Enable low then re-enable
        en_in = 1'b0;
        seen = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            seen = seen | outs;
        end
        check("dis_outputs_zero", 32'(seen), 0);
        load(5, 0);
        check("dis_load_immediate", 32'(cfg_pending_out), 0);
        en_in = 1'b1;
        @(negedge clk_in); c0 = cyc;
        check("reen_clk_high", 32'(clk_out), 1);
        wait_sig(0, 20, at); check("reen_os1", at - c0, 5);
        prev = at;
        wait_sig(0, 20, at); check("reen_space", at - prev, 5);

        // Async reset mid-operation
        wait_sig(2, 200, at);
        load(7, 0);
        check("arst_pre_pending", 32'(cfg_pending_out), 1);
        check("arst_pre_clk", 32'(clk_out), 1);
        #2 nrst_in = 1'b0;
        #1 check("arst_outputs_clear", 32'(outs), 0);
        @(negedge clk_in);
        nrst_in = 1'b1;
        @(negedge clk_in); c0 = cyc;
        wait_sig(0, 200, at); check("arst_div_reverts", at - c0, 54);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_baud_tick_gen
`default_nettype wire
